vga_sync_gen: RTL and testbench

Generates the 640x480@60 Hz VGA raster timing that every pixel-painting block in the game consumes: horizontal/vertical sync, the `bright` visible-area flag, and the `hCount`/`vCount` raster position. It also produces a pixel-rate enable, a once-per-frame strobe and a frame counter, so game logic can advance object positions once per frame. It is the timing source feeding the block/obstacle painters and the board's VGA connector.

---
 rtl/vga_sync_gen.sv | 120 ++++++++++++
 tb/tb_vga_sync_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_gen
//  Purpose  : 640x480@60 Hz VGA raster timing source. Divides the system
//             clock down to the pixel rate, walks the horizontal and vertical
//             raster counters, and produces registered sync, visible-area,
//             pixel-enable, frame-strobe and frame-count outputs.
//  Ports    : clk        - system clock (100 MHz)
//             rst        - asynchronous reset, active low
//             hSync      - horizontal sync, active low
//             vSync      - vertical sync, active low
//             bright     - raster position is inside the visible window
//             hCount     - horizontal pixel position
//             vCount     - line position
//             pix_en     - one-clk pulse per pixel period
//             frame_tick - one-clk pulse at the start of each frame
//             frame_cnt  - completed frames, modulo 256
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       pix_en,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] c_H_LAST      = 10'(H_SYNC + H_BP + H_VIS + H_FP - 1);
    localparam logic [9:0] c_V_LAST      = 10'(V_SYNC + V_BP + V_VIS + V_FP - 1);
    localparam logic [9:0] c_H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] c_V_SYNC_END  = 10'(V_SYNC);
    // Visible window bounds; the *_END values are exclusive.
    localparam logic [9:0] c_H_VIS_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] c_H_VIS_END   = 10'(H_SYNC + H_BP + H_VIS);
    localparam logic [9:0] c_V_VIS_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] c_V_VIS_END   = 10'(V_SYNC + V_BP + V_VIS);

    logic [DIV_W-1:0] r_div;

    logic [DIV_W-1:0] w_div_nxt;
    logic             w_adv;
    logic             w_h_end;
    logic             w_v_end;
    logic             w_frame_wrap;
    logic [9:0]       w_h_nxt;
    logic [9:0]       w_v_nxt;
    logic             w_h_vis;
    logic             w_v_vis;

    // The raster advances on the edge that closes the last divider phase,
    // which is the same cycle in which pix_en is presented high.
    assign w_adv        = (r_div == c_DIV_LAST);
    assign w_div_nxt    = w_adv ? '0 : r_div + 1'b1;
    assign w_h_end      = (hCount == c_H_LAST);
    assign w_v_end      = (vCount == c_V_LAST);
    assign w_frame_wrap = w_adv && w_h_end && w_v_end;

    always_comb begin
        w_h_nxt = hCount;
        w_v_nxt = vCount;
        if (w_adv) begin
            w_h_nxt = w_h_end ? 10'd0 : hCount + 10'd1;
            if (w_h_end) begin
                w_v_nxt = w_v_end ? 10'd0 : vCount + 10'd1;
            end
        end
    end

    // Decode from the next-state counts so the registered sync and bright
    // outputs line up with the counts they describe.
    assign w_h_vis = (w_h_nxt >= c_H_VIS_START) && (w_h_nxt < c_H_VIS_END);
    assign w_v_vis = (w_v_nxt >= c_V_VIS_START) && (w_v_nxt < c_V_VIS_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div      <= '0;
            pix_en     <= 1'b0;
            hCount     <= 10'd0;
            vCount     <= 10'd0;
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            bright     <= 1'b0;
            frame_tick <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            r_div      <= w_div_nxt;
            pix_en     <= (w_div_nxt == c_DIV_LAST);
            hCount     <= w_h_nxt;
            vCount     <= w_v_nxt;
            hSync      <= (w_h_nxt >= c_H_SYNC_END);
            vSync      <= (w_v_nxt >= c_V_SYNC_END);
            bright     <= w_h_vis && w_v_vis;
            frame_tick <= w_frame_wrap;
            if (w_frame_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync_gen
//  Purpose  : Self-checking bench for vga_sync_gen. Three instances: the
//             full 640x480 configuration, one with full horizontal timing
//             and a short frame, and a tiny one that wraps frame_cnt quickly.
//             Every cycle is compared with an arithmetic raster model, and a
//             table of hand-computed checkpoints is compared on the way.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_br, a_pe, a_ft;
    logic [9:0] a_h, a_v;
    logic [7:0] a_fc;
    logic       b_hs, b_vs, b_br, b_pe, b_ft;
    logic [9:0] b_h, b_v;
    logic [7:0] b_fc;
    logic       c_hs, c_vs, c_br, c_pe, c_ft;
    logic [9:0] c_h, c_v;
    logic [7:0] c_fc;

    vga_sync_gen u_a (
        .clk(clk), .rst(rst), .hSync(a_hs), .vSync(a_vs), .bright(a_br),
        .hCount(a_h), .vCount(a_v), .pix_en(a_pe), .frame_tick(a_ft),
        .frame_cnt(a_fc)
    );

    vga_sync_gen #(
        .V_SYNC(2), .V_BP(1), .V_VIS(2), .V_FP(1)
    ) u_b (
        .clk(clk), .rst(rst), .hSync(b_hs), .vSync(b_vs), .bright(b_br),
        .hCount(b_h), .vCount(b_v), .pix_en(b_pe), .frame_tick(b_ft),
        .frame_cnt(b_fc)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_SYNC(2), .H_BP(1), .H_VIS(2), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_VIS(2), .V_FP(1)
    ) u_c (
        .clk(clk), .rst(rst), .hSync(c_hs), .vSync(c_vs), .bright(c_br),
        .hCount(c_h), .vCount(c_v), .pix_en(c_pe), .frame_tick(c_ft),
        .frame_cnt(c_fc)
    );

    int total = 0;
    int bad   = 0;

    // Packed layout: {frame_cnt, hCount, vCount, hSync, vSync, bright, pix_en, frame_tick}
    function automatic logic [32:0] pk(input logic [7:0] fc, input logic [9:0] h,
                                       input logic [9:0] v, input logic hs,
                                       input logic vs, input logic br,
                                       input logic pe, input logic ft);
        return {fc, h, v, hs, vs, br, pe, ft};
    endfunction

    // Raster position derived directly from elapsed clock edges since release.
    function automatic logic [32:0] model(input int n, input int d,
                                          input int hs, input int hbp, input int hvis, input int hfp,
                                          input int vs, input int vbp, input int vvis, input int vfp);
        int ht, vt, p, h, v, f;
        logic pe, ft, hsy, vsy, br;
        ht  = hs + hbp + hvis + hfp;
        vt  = vs + vbp + vvis + vfp;
        p   = n / d;
        h   = p % ht;
        v   = (p / ht) % vt;
        f   = (p / (ht * vt)) % 256;
        pe  = ((n % d) == d - 1);
        ft  = (p > 0) && ((p % (ht * vt)) == 0) && ((n % d) == 0);
        hsy = !(h < hs);
        vsy = !(v < vs);
        br  = (h >= hs + hbp) && (h < hs + hbp + hvis) &&
              (v >= vs + vbp) && (v < vs + vbp + vvis);
        return pk(8'(f), 10'(h), 10'(v), hsy, vsy, br, pe, ft);
    endfunction

    task automatic check(input string name, input int n, input logic [32:0] act,
                         input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s n=%0d actual=%h required=%h", name, n, act, exp);
        end
    endtask

    typedef struct {
        int         n;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs, vs, br, pe, ft;
        logic [7:0] fc;
    } tvec_t;

    localparam int NT = 19;
    tvec_t tbl[NT];

    function automatic tvec_t mk(input int n, input int h, input int v,
                                 input logic hs, input logic vs, input logic br,
                                 input logic pe, input logic ft, input int fc);
        tvec_t t;
        t.n = n; t.h = 10'(h); t.v = 10'(v);
        t.hs = hs; t.vs = vs; t.br = br; t.pe = pe; t.ft = ft; t.fc = 8'(fc);
        return t;
    endfunction

    logic [32:0] a_act, b_act, c_act;
    assign a_act = pk(a_fc, a_h, a_v, a_hs, a_vs, a_br, a_pe, a_ft);
    assign b_act = pk(b_fc, b_h, b_v, b_hs, b_vs, b_br, b_pe, b_ft);
    assign c_act = pk(c_fc, c_h, c_v, c_hs, c_vs, c_br, c_pe, c_ft);

    task automatic hold_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("rst_a", i, a_act, 33'd0);
            check("rst_b", i, b_act, 33'd0);
            check("rst_c", i, c_act, 33'd0);
        end
    endtask

    // Releases reset on a falling edge and checks every cycle for ncyc cycles.
    task automatic run_phase(input int ncyc);
        int tidx;
        tvec_t t;
        tidx = 0;
        rst  = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            check("model_a", n, a_act, model(n, 4, 96, 48, 640, 16, 2, 33, 480, 10));
            check("model_b", n, b_act, model(n, 4, 96, 48, 640, 16, 2, 1, 2, 1));
            check("model_c", n, c_act, model(n, 2, 2, 1, 2, 1, 1, 1, 2, 1));
            if (tidx < NT && tbl[tidx].n == n) begin
                t = tbl[tidx];
                check("table_b", n, b_act, pk(t.fc, t.h, t.v, t.hs, t.vs, t.br, t.pe, t.ft));
                tidx++;
            end
            if (n == 3200) begin
                check("a_line_wrap", n, {12'd0, a_h, a_v}, {12'd0, 10'd0, 10'd1});
            end
            if (n == 15300) begin
                check("c_fc_255", n, {23'd0, c_fc, c_ft}, {23'd0, 8'd255, 1'b1});
            end
            if (n == 15360) begin
                check("c_fc_wrap", n, {23'd0, c_fc, c_ft}, {23'd0, 8'd0, 1'b1});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        tbl[0]  = mk(0,     0,   0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(3,     0,   0, 0, 0, 0, 1, 0, 0);
        tbl[2]  = mk(4,     1,   0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(383,   95,  0, 0, 0, 0, 1, 0, 0);
        tbl[4]  = mk(384,   96,  0, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(3199,  799, 0, 1, 0, 0, 1, 0, 0);
        tbl[6]  = mk(3200,  0,   1, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(6400,  0,   2, 0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(6976,  144, 2, 1, 1, 0, 0, 0, 0);
        tbl[9]  = mk(10172, 143, 3, 1, 1, 0, 0, 0, 0);
        tbl[10] = mk(10176, 144, 3, 1, 1, 1, 0, 0, 0);
        tbl[11] = mk(12732, 783, 3, 1, 1, 1, 0, 0, 0);
        tbl[12] = mk(12735, 783, 3, 1, 1, 1, 1, 0, 0);
        tbl[13] = mk(12736, 784, 3, 1, 1, 0, 0, 0, 0);
        tbl[14] = mk(16576, 144, 5, 1, 1, 0, 0, 0, 0);
        tbl[15] = mk(19199, 799, 5, 1, 1, 0, 1, 0, 0);
        tbl[16] = mk(19200, 0,   0, 0, 0, 0, 0, 1, 1);
        tbl[17] = mk(19201, 0,   0, 0, 0, 0, 0, 0, 1);
        tbl[18] = mk(38400, 0,   0, 0, 0, 0, 0, 1, 2);

        rst = 1'b0;
        hold_reset(int'($urandom_range(3, 12)));
        run_phase(40000 + int'($urandom_range(0, 999)));

        // Asynchronous reset in the middle of a pixel, away from any clock edge.
        #2 rst = 1'b0;
        #1;
        check("async_rst_a", -1, a_act, 33'd0);
        check("async_rst_b", -1, b_act, 33'd0);
        check("async_rst_c", -1, c_act, 33'd0);
        hold_reset(int'($urandom_range(2, 8)));
        run_phase(4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
